// File: rtl/password_pkg.sv
// Shared definitions for the password lock: FSM states, button symbol codes,
// parameter defaults, the power-up password and the LED helpers.
package password_pkg;

  typedef enum logic [1:0] {
    IDLE_ARMED,
    UNLOCKED,
    EXPLODED
  } state_t;

  localparam logic [1:0] CODE_BTN0 = 2'd0;
  localparam logic [1:0] CODE_BTN1 = 2'd1;
  localparam logic [1:0] CODE_BTN2 = 2'd2;

  localparam int unsigned PW_LEN_DEF   = 4;
  localparam int unsigned MAX_FAIL_DEF = 3;

  // Power-up password, oldest symbol first.
  localparam logic [1:0] DEFAULT_PW [4] = '{CODE_BTN0, CODE_BTN1, CODE_BTN2, CODE_BTN0};

  localparam logic [3:0] LED_UNLOCKED = 4'b1111;
  localparam logic [3:0] LED_EXPLODED = 4'b1010;

  // Longer passwords repeat the default pattern.
  function automatic logic [1:0] default_code(input int unsigned i);
    return DEFAULT_PW[i[1:0]];
  endfunction

  // Thermometer code on the 4-bit display; counts above 4 show all LEDs lit.
  function automatic logic [3:0] therm(input int unsigned n);
    logic [3:0] t;
    for (int unsigned i = 0; i < 4; i++) t[i] = (i < n);
    return t;
  endfunction

endpackage

// File: rtl/password_btn_edge.sv
// btn_edge: registers one push button and flags a press.
//   clk, async_nreset : clock, asynchronous active-low reset
//   btn               : raw button level, synchronous to clk
//   press             : one-cycle pulse on a 0->1 transition of the sampled level
module btn_edge (
  input  logic clk,
  input  logic async_nreset,
  input  logic btn,
  output logic press
);

  logic sample;
  logic prev;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sample <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sample <= btn;
      prev   <= sample;
    end
  end

  assign press = sample & ~prev;

endmodule

// File: rtl/password.sv
// password: three-button combination lock.
//   clk, async_nreset  : clock, asynchronous active-low reset
//   btn0, btn1, btn2   : buttons carrying symbols 0, 1, 2
//   mode               : 0 = program the password, 1 = unlock attempt
//   unlocked, explode  : sticky result flags (mutually exclusive)
//   led                : progress thermometer, or 1111 unlocked / 1010 exploded
module password
  import password_pkg::*;
#(
  parameter int unsigned PW_LEN   = PW_LEN_DEF,
  parameter int unsigned MAX_FAIL = MAX_FAIL_DEF
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       btn0,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       mode,
  output logic       unlocked,
  output logic       explode,
  output logic [3:0] led
);

  localparam int unsigned IDX_W  = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
  localparam int unsigned PRG_W  = $clog2(PW_LEN + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [PRG_W-1:0]  prg_cnt;
  logic [FAIL_W-1:0] fail_cnt;
  logic [1:0]        pw    [PW_LEN];
  logic [1:0]        entry [PW_LEN];

  logic p0, p1, p2;
  logic mode_s, mode_p;
  logic mode_chg;
  logic press_ok;
  logic [1:0] code;
  logic attempt_ok;

  btn_edge u_edge0 (.clk(clk), .async_nreset(async_nreset), .btn(btn0), .press(p0));
  btn_edge u_edge1 (.clk(clk), .async_nreset(async_nreset), .btn(btn1), .press(p1));
  btn_edge u_edge2 (.clk(clk), .async_nreset(async_nreset), .btn(btn2), .press(p2));

  // Mode is delayed like the buttons so a mode change and a press that were
  // driven together land in the same cycle, where the press is dropped.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      mode_s <= 1'b0;
      mode_p <= 1'b0;
    end else begin
      mode_s <= mode;
      mode_p <= mode_s;
    end
  end

  assign mode_chg = mode_s ^ mode_p;
  assign press_ok = $onehot({p2, p1, p0});
  assign code     = p2 ? CODE_BTN2 : (p1 ? CODE_BTN1 : CODE_BTN0);

  // Final press is compared directly, the earlier ones come from entry[].
  always_comb begin
    attempt_ok = (code == pw[PW_LEN-1]);
    for (int unsigned i = 0; i < PW_LEN - 1; i++) begin
      if (entry[i] != pw[i]) attempt_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state    <= IDLE_ARMED;
      idx      <= '0;
      prg_cnt  <= '0;
      fail_cnt <= '0;
      unlocked <= 1'b0;
      explode  <= 1'b0;
      led      <= '0;
      for (int unsigned i = 0; i < PW_LEN; i++) begin
        pw[i]    <= default_code(i);
        entry[i] <= '0;
      end
    end else begin
      case (state)
        IDLE_ARMED: begin
          if (mode_chg) begin
            idx     <= '0;
            prg_cnt <= '0;
            led     <= '0;
          end else if (press_ok) begin
            if (!mode_s) begin
              for (int unsigned i = 0; i < PW_LEN - 1; i++) pw[i] <= pw[i+1];
              pw[PW_LEN-1] <= code;
              if (prg_cnt != PRG_W'(PW_LEN)) begin
                prg_cnt <= prg_cnt + PRG_W'(1);
                led     <= therm(32'(prg_cnt) + 32'd1);
              end
            end else begin
              entry[idx] <= code;
              if (idx == IDX_W'(PW_LEN - 1)) begin
                idx <= '0;
                if (attempt_ok) begin
                  state    <= UNLOCKED;
                  unlocked <= 1'b1;
                  led      <= LED_UNLOCKED;
                end else begin
                  fail_cnt <= fail_cnt + FAIL_W'(1);
                  if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
                    state   <= EXPLODED;
                    explode <= 1'b1;
                    led     <= LED_EXPLODED;
                  end else begin
                    led <= '0;
                  end
                end
              end else begin
                idx <= idx + IDX_W'(1);
                led <= therm(32'(idx) + 32'd1);
              end
            end
          end
        end
        default: ;  // UNLOCKED / EXPLODED hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_password.sv
module tb_password;

  logic       clk = 1'b0;
  logic       async_nreset = 1'b0;
  logic [2:0] btns = '0;
  logic       mode = 1'b0;
  logic       unlocked;
  logic       explode;
  logic [3:0] led;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  password #(.PW_LEN(4), .MAX_FAIL(3)) dut (
    .clk(clk),
    .async_nreset(async_nreset),
    .btn0(btns[0]),
    .btn1(btns[1]),
    .btn2(btns[2]),
    .mode(mode),
    .unlocked(unlocked),
    .explode(explode),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the buttons in mask for one cycle, then wait until the effect shows.
  task automatic press(input logic [2:0] mask);
    @(negedge clk) btns = mask;
    @(negedge clk) btns = '0;
    cycles(2);
  endtask

  task automatic set_mode(input logic m);
    @(negedge clk) mode = m;
    cycles(3);
  endtask

  task automatic do_reset();
    @(negedge clk) async_nreset = 1'b0;
    btns = '0;
    #1;
    check("reset_led", 32'(led), 32'h0);
    check("reset_flags", {30'd0, unlocked, explode}, 32'h0);
    @(negedge clk) mode = 1'b0;
    @(negedge clk) async_nreset = 1'b1;
    cycles(2);
  endtask

  initial begin
    cycles(2);
    do_reset();

    // Default password 0,1,2,0 unlocks.
    set_mode(1'b1);
    press(3'b001);
    check("unl_led1", 32'(led), 32'h1);
    press(3'b010);
    check("unl_led2", 32'(led), 32'h3);
    press(3'b100);
    check("unl_led3", 32'(led), 32'h7);
    press(3'b001);
    check("unl_flag", 32'(unlocked), 32'h1);
    check("unl_led", 32'(led), 32'hF);
    press(3'b010);
    set_mode(1'b0);
    check("unl_sticky", {28'd0, led}, 32'hF);

    // Program 0,1,2,0,1,2 -> password 2,0,1,2.
    do_reset();
    press(3'b001);
    check("prg_led1", 32'(led), 32'h1);
    press(3'b010);
    check("prg_led2", 32'(led), 32'h3);
    press(3'b100);
    press(3'b001);
    check("prg_led4", 32'(led), 32'hF);
    press(3'b010);
    press(3'b100);
    check("prg_led6", 32'(led), 32'hF);

    // Unlock mode, btn0 held for 100 cycles counts once.
    set_mode(1'b1);
    check("mode_clr_led", 32'(led), 32'h0);
    @(negedge clk) btns = 3'b001;
    cycles(3);
    for (int i = 0; i < 97; i++) begin
      check("hold_led", 32'(led), 32'h1);
      @(negedge clk);
    end
    btns = '0;
    cycles(2);
    check("hold_led_end", 32'(led), 32'h1);
    check("hold_unl", 32'(unlocked), 32'h0);
    // Finish that attempt wrong, then enter the programmed 2,0,1,2.
    press(3'b010);
    press(3'b010);
    press(3'b010);
    check("fail1_led", 32'(led), 32'h0);
    check("fail1_unl", 32'(unlocked), 32'h0);
    press(3'b100);
    press(3'b001);
    press(3'b010);
    press(3'b100);
    check("prog_pw_unl", 32'(unlocked), 32'h1);
    check("prog_pw_led", 32'(led), 32'hF);

    // Three wrong attempts explode.
    do_reset();
    set_mode(1'b1);
    for (int a = 0; a < 3; a++) begin
      for (int p = 0; p < 4; p++) press(3'b010);
      if (a < 2) check("wrong_led", 32'(led), 32'h0);
    end
    check("expl_flag", 32'(explode), 32'h1);
    check("expl_led", 32'(led), 32'hA);
    check("expl_excl", 32'(unlocked), 32'h0);
    press(3'b001);
    press(3'b010);
    press(3'b100);
    press(3'b001);
    set_mode(1'b0);
    press(3'b001);
    check("expl_hold", {26'd0, unlocked, explode, led}, 32'h1A);

    // Program 2,2,2,2; simultaneous presses ignored; reset mid-entry.
    do_reset();
    for (int p = 0; p < 4; p++) press(3'b100);
    set_mode(1'b1);
    press(3'b001);
    press(3'b010);
    check("partial_led", 32'(led), 32'h3);
    press(3'b011);
    check("simul_led", 32'(led), 32'h3);
    do_reset();
    check("post_rst_led", 32'(led), 32'h0);
    set_mode(1'b1);
    press(3'b001);
    press(3'b010);
    press(3'b100);
    press(3'b001);
    check("default_restored", 32'(unlocked), 32'h1);
    check("default_led", 32'(led), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/password.md
PASSWORD -- requirements
Module: password

Interface
REQ-001 The block SHALL have parameter PW_LEN, default 4, meaning the number of button presses in one password.
REQ-002 The block SHALL have parameter MAX_FAIL, default 3, meaning the number of wrong attempts that triggers explode.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port async_nreset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports btn0, btn1 and btn2, input, 1 bit each: push buttons carrying symbol codes 0, 1 and 2; inputs are synchronous to clk.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = program the password, 1 = unlock attempt.
REQ-007 The block SHALL have port unlocked, output, 1 bit: sticky flag, high once a correct password has been entered.
REQ-008 The block SHALL have port explode, output, 1 bit: sticky flag, high once MAX_FAIL wrong attempts have been made.
REQ-009 The block SHALL have port led, output, 4 bits: progress and status display.

Function
REQ-010 The block SHALL register each button, and a press SHALL be a rising edge: sampled value 1 with the previous sample 0.
REQ-011 A held button SHALL count as exactly one press.
REQ-012 If presses on two or more buttons occur in the same cycle, the block SHALL ignore all of them.
REQ-013 The effect of a press SHALL be visible on the outputs one clock after the edge at which it is detected.
REQ-014 The password SHALL be a PW_LEN x 2-bit shift register; its reset value SHALL be codes 0,1,2,0 (oldest first).
REQ-015 In program mode (mode=0), each press SHALL shift its code into the password register, so the last PW_LEN presses form the password.
REQ-016 In program mode, prg_cnt SHALL increment on each press and saturate at PW_LEN.
REQ-017 In program mode, led SHALL show a thermometer of prg_cnt (for example, 2 presses -> 4'b0011).
REQ-018 In unlock mode (mode=1), each press SHALL be stored at entry position idx (0..PW_LEN-1), and idx SHALL then increment.
REQ-019 In unlock mode, led SHALL show a thermometer of idx.
REQ-020 On the PW_LEN-th press of an attempt, the entered sequence SHALL be compared with the password; idx SHALL then return to 0.
REQ-021 On a match, unlocked SHALL be set.
REQ-022 On a mismatch, fail_cnt SHALL increment; when fail_cnt reaches MAX_FAIL, explode SHALL be set.
REQ-023 Any change of mode SHALL clear idx and prg_cnt in the cycle after the change; a press in that same cycle SHALL be ignored.
REQ-024 States SHALL be IDLE_ARMED, UNLOCKED and EXPLODED.
REQ-025 In UNLOCKED and EXPLODED, all buttons and mode SHALL be ignored until reset.
REQ-026 In UNLOCKED, led SHALL be 4'b1111; in EXPLODED, led SHALL be 4'b1010.
REQ-027 unlocked and explode SHALL never be high at the same time.

Reset
REQ-028 Asserting async_nreset low SHALL immediately set: unlocked=0, explode=0, led=0, idx=0, prg_cnt=0, fail_cnt=0, the password to its reset value, button history to 0, and the state to IDLE_ARMED.
REQ-029 Reset asserted mid-entry SHALL discard the partial attempt and any programmed password.

Structure
REQ-030 A shared package SHALL hold: the state enum, the button code constants (0, 1, 2), the PW_LEN and MAX_FAIL defaults, and the default password.
REQ-031 The block SHALL use one sub-module, btn_edge, which registers a button and outputs a one-cycle press pulse; it SHALL be instantiated three times.

Verification
REQ-032 Reset, then mode=1 and presses btn0, btn1, btn2, btn0 -> unlocked=1, led=4'b1111.
REQ-033 mode=0 and presses btn0, btn1, btn2, btn0, btn1, btn2 -> led=4'b1111 after the 4th press; the password becomes 2,0,1,2.
REQ-034 After the REQ-033 programming, mode=1 and btn0 held high for 100 cycles -> led=4'b0001 for the whole hold, unlocked=0.
REQ-035 Three wrong 4-press attempts (for example btn1 x4) -> explode=1 and led=4'b1010; any later presses leave the outputs unchanged.
REQ-036 btn0 and btn1 rising in the same cycle -> idx unchanged; reset asserted after 2 presses -> led=0, and the default password is restored.
